// File: rtl/ifetch_icache_unit.sv
// Instruction fetch stage: PC register plus direct-mapped I-cache with line refill.
// Optional hit/miss performance counters are enabled with IFETCH_PERF_EN.
module ifetch_icache_unit #(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc,
    output logic [31:0] instruction,
`ifdef IFETCH_PERF_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    output logic        hit
);

    localparam int OB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - OB - IB;
    localparam logic [OB-1:0] LAST = OB'(WORDS_PER_LINE - 1);
    localparam logic [OB-1:0] ONE  = OB'(1);

    typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [OB-1:0]     cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              pend_q, pend_d;
    logic [31:0]       pend_pc_q, pend_pc_d;

    logic [TW-1:0]     tag_q [LINES];
    logic [31:0]       data_q [LINES*WORDS_PER_LINE];
    logic              data_we, tag_we;
    logic [31:0]       data_d;
    logic [TW-1:0]     tag_d;

    logic [OB-1:0]     off;
    logic [IB-1:0]     idx;
    logic [TW-1:0]     tag;
    logic [OB-1:0]     cnt_nxt;
    logic [31:0]       redir_pc;
    logic              hit_w;

    assign off      = pc_q[OB+1:2];
    assign idx      = pc_q[OB+IB+1:OB+2];
    assign tag      = pc_q[31:OB+IB+2];
    assign cnt_nxt  = cnt_q + ONE;
    assign redir_pc = redirect_target & 32'hFFFF_FFFC;
    assign hit_w    = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);

    assign hit         = hit_w;
    assign instruction = hit_w ? data_q[{idx, off}] : 32'h0;
    assign pc_out      = pc_q;
    assign next_pc     = pc_q + 32'd4;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // Next-state: PC steering, miss detection and line refill sequencing.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        data_d     = mem_rdata;
        tag_d      = tag;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d   = redir_pc;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_pc_q;
                    pend_d = 1'b0;
                end else if (!hit_w) begin
                    state_d    = REFILL;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_q[31:OB+2], {(OB+2){1'b0}}};
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            REFILL: begin
                if (redirect) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redir_pc;
                end
                if (mem_ready) begin
                    data_we = 1'b1;
                    if (cnt_q == LAST) begin
                        tag_we       = 1'b1;
                        valid_d[idx] = 1'b1;
                        mem_req_d    = 1'b0;
                        cnt_d        = '0;
                        state_d      = FILL_DONE;
                    end else begin
                        cnt_d      = cnt_nxt;
                        mem_addr_d = {pc_q[31:OB+2], cnt_nxt, 2'b00};
                    end
                end
            end
            FILL_DONE: begin
                if (redirect) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redir_pc;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and PC registers, synchronously reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // Tag and data arrays; contents are meaningless until valid is set.
    always_ff @(posedge clock) begin
        if (data_we && !reset) begin
            data_q[{idx, cnt_q}] <= data_d;
        end
        if (tag_we && !reset) begin
            tag_q[idx] <= tag_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Count consumed hits and refill starts.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_w && !stall) hit_count_d = hit_count_q + 32'd1;
        if (state_q == IDLE && state_d == REFILL) miss_count_d = miss_count_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_icache_unit.sv
// Directed testbench for ifetch_icache_unit.
// Memory returns a fixed function of the word address.
module tb_ifetch_icache_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] pc_out;
    logic [31:0] next_pc;
    logic [31:0] instruction;
    logic        hit;
`ifdef IFETCH_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;

    ifetch_icache_unit dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .pc_out(pc_out),
        .next_pc(next_pc),
        .instruction(instruction),
`ifdef IFETCH_PERF_EN
        .hit_count(hit_count),
        .miss_count(miss_count),
`endif
        .hit(hit)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign mem_rdata = memf(mem_addr);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        mem_ready = 1'b1;
        run(2);
        tests++;
        if ({pc_out, next_pc} !== {32'h0, 32'h4}) begin
            $display("FAIL reset_pc: got %h/%h want 0/4", pc_out, next_pc);
            fails++;
        end
        tests++;
        if ({hit, instruction} !== {1'b0, 32'h0}) begin
            $display("FAIL reset_hit: got %b/%h want 0/0", hit, instruction);
            fails++;
        end
        tests++;
        if ({mem_req, mem_addr} !== {1'b0, 32'h0}) begin
            $display("FAIL reset_mem: got %b/%h want 0/0", mem_req, mem_addr);
            fails++;
        end
        reset = 1'b0;
    endtask

    task automatic test_cold_fill();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if ({mem_req, mem_addr} !== {1'b1, 32'(k * 4)}) begin
                $display("FAIL cold_beat%0d: got %b/%h want 1/%h",
                         k, mem_req, mem_addr, 32'(k * 4));
                fails++;
            end
        end
        tick();
        tests++;
        if ({mem_req, hit} !== 2'b00) begin
            $display("FAIL cold_filldone: got req=%b hit=%b want 0/0", mem_req, hit);
            fails++;
        end
        tick();
        tests++;
        if ({hit, instruction, next_pc, pc_out} !== {1'b1, memf(32'h0), 32'h4, 32'h0}) begin
            $display("FAIL cold_hit: got %b/%h/%h/%h want 1/%h/4/0",
                     hit, instruction, next_pc, pc_out, memf(32'h0));
            fails++;
        end
`ifdef IFETCH_PERF_EN
        tests++;
        if (miss_count !== 32'd1) begin
            $display("FAIL cold_misscnt: got %0d want 1", miss_count);
            fails++;
        end
`endif
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests++;
            if ({pc_out, hit, instruction} !== {32'(4 * k), 1'b1, memf(32'(4 * k))}) begin
                $display("FAIL seq_pc%0d: got %h/%b/%h want %h/1/%h",
                         k, pc_out, hit, instruction, 32'(4 * k), memf(32'(4 * k)));
                fails++;
            end
        end
        tick();
        tests++;
        if ({pc_out, hit, instruction} !== {32'h10, 1'b0, 32'h0}) begin
            $display("FAIL seq_miss: got %h/%b/%h want 10/0/0", pc_out, hit, instruction);
            fails++;
        end
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin
            $display("FAIL seq_refill: got %b/%h want 1/10", mem_req, mem_addr);
            fails++;
        end
        run(5);
        tests++;
        if ({pc_out, hit, instruction} !== {32'h10, 1'b1, memf(32'h10)}) begin
            $display("FAIL seq_fill16: got %h/%b/%h want 10/1/%h",
                     pc_out, hit, instruction, memf(32'h10));
            fails++;
        end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1;
        redirect_target = 32'h43;
        tick();
        redirect = 1'b0;
        tests++;
        if ({pc_out, hit} !== {32'h40, 1'b0}) begin
            $display("FAIL redir_pc: got %h/%b want 40/0", pc_out, hit);
            fails++;
        end
        run(6);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({pc_out, hit, instruction} !== {32'h40, 1'b1, memf(32'h40)}) begin
                $display("FAIL stall_hold%0d: got %h/%b/%h want 40/1/%h",
                         k, pc_out, hit, instruction, memf(32'h40));
                fails++;
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_in_refill();
        redirect = 1'b1;
        redirect_target = 32'h50;
        tick();
        redirect = 1'b0;
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h50}) begin
            $display("FAIL rr_start: got %b/%h want 1/50", mem_req, mem_addr);
            fails++;
        end
        redirect = 1'b1;
        redirect_target = 32'h83;
        tick();
        redirect = 1'b0;
        tests++;
        if ({mem_req, mem_addr, pc_out} !== {1'b1, 32'h54, 32'h50}) begin
            $display("FAIL rr_continue: got %b/%h/%h want 1/54/50", mem_req, mem_addr, pc_out);
            fails++;
        end
        run(4);
        tests++;
        if ({pc_out, hit, instruction} !== {32'h50, 1'b1, memf(32'h50)}) begin
            $display("FAIL rr_installed: got %h/%b/%h want 50/1/%h",
                     pc_out, hit, instruction, memf(32'h50));
            fails++;
        end
        tick();
        tests++;
        if ({pc_out, hit} !== {32'h80, 1'b0}) begin
            $display("FAIL rr_pending: got %h/%b want 80/0", pc_out, hit);
            fails++;
        end
        tick();
        mem_ready = 1'b0;
        run(2);
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
            $display("FAIL rr_wait: got %b/%h want 1/80", mem_req, mem_addr);
            fails++;
        end
        mem_ready = 1'b1;
        run(5);
        tests++;
        if ({pc_out, hit, instruction} !== {32'h80, 1'b1, memf(32'h80)}) begin
            $display("FAIL rr_fill80: got %h/%b/%h want 80/1/%h",
                     pc_out, hit, instruction, memf(32'h80));
            fails++;
        end
    endtask

    task automatic test_conflict();
        redirect = 1'b1;
        redirect_target = 32'h0;
        tick();
        tests++;
        if ({pc_out, hit, instruction} !== {32'h0, 1'b1, memf(32'h0)}) begin
            $display("FAIL cf_line0: got %h/%b/%h want 0/1/%h",
                     pc_out, hit, instruction, memf(32'h0));
            fails++;
        end
        redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        tests++;
        if ({pc_out, hit} !== {32'h100, 1'b0}) begin
            $display("FAIL cf_miss100: got %h/%b want 100/0", pc_out, hit);
            fails++;
        end
        run(6);
        tests++;
        if ({hit, instruction} !== {1'b1, memf(32'h100)}) begin
            $display("FAIL cf_fill100: got %b/%h want 1/%h", hit, instruction, memf(32'h100));
            fails++;
        end
        redirect = 1'b1;
        redirect_target = 32'h0;
        tick();
        tests++;
        if ({pc_out, hit} !== {32'h0, 1'b0}) begin
            $display("FAIL cf_evicted: got %h/%b want 0/0", pc_out, hit);
            fails++;
        end
        redirect_target = 32'h40;
        tick();
        redirect = 1'b0;
        tests++;
        if ({pc_out, hit, mem_req} !== {32'h40, 1'b1, 1'b0}) begin
            $display("FAIL cf_redir_wins: got %h/%b/%b want 40/1/0", pc_out, hit, mem_req);
            fails++;
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFF0}) begin
            $display("FAIL wrap_refill: got %b/%h want 1/fffffff0", mem_req, mem_addr);
            fails++;
        end
        run(5);
        tests++;
        if ({hit, instruction, next_pc} !== {1'b1, memf(32'hFFFF_FFFC), 32'h0}) begin
            $display("FAIL wrap_hit: got %b/%h/%h want 1/%h/0",
                     hit, instruction, next_pc, memf(32'hFFFF_FFFC));
            fails++;
        end
        tick();
        tests++;
        if ({pc_out, hit} !== {32'h0, 1'b0}) begin
            $display("FAIL wrap_to0: got %h/%b want 0/0", pc_out, hit);
            fails++;
        end
    endtask

    task automatic test_reset_mid_refill();
        run(2);
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin
            $display("FAIL rm_beat2: got %b/%h want 1/4", mem_req, mem_addr);
            fails++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({mem_req, pc_out, hit} !== {1'b0, 32'h0, 1'b0}) begin
            $display("FAIL rm_reset: got %b/%h/%b want 0/0/0", mem_req, pc_out, hit);
            fails++;
        end
        tick();
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin
            $display("FAIL rm_restart: got %b/%h want 1/0", mem_req, mem_addr);
            fails++;
        end
        run(5);
        tests++;
        if ({pc_out, hit, instruction} !== {32'h0, 1'b1, memf(32'h0)}) begin
            $display("FAIL rm_refill: got %h/%b/%h want 0/1/%h",
                     pc_out, hit, instruction, memf(32'h0));
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_sequential();
        test_redirect_stall();
        test_redirect_in_refill();
        test_conflict();
        test_wrap();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
